sps_match_ctrl: RTL and testbench
=================================

SPS_MATCH_CTRL -- requirements
Module: sps_match_ctrl

Interface
REQ-001 Parameter WIN_TARGET, default 3: round wins needed to take the match (range 1..15).
REQ-002 Parameter RESULT_LAT, default 2: cycles from eng_start to a valid eng_winner (range 1..7).
REQ-003 The block has one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 go  in  1  one-cycle strobe that starts a match; ignored unless in IDLE or DONE.
REQ-007 p1_move  in  2  player-1 move (00 stone, 01 paper, 10 scissors, 11 invalid).
REQ-008 p1_valid  in  1  player-1 move qualifier.
REQ-009 p2_move  in  2  player-2 move, same encoding.
REQ-010 p2_valid  in  1  player-2 move qualifier.
REQ-011 eng_p1, eng_p2  out  2 each  moves presented to the game engine.
REQ-012 eng_start  out  1  one-cycle round-start pulse to the engine.
REQ-013 eng_winner  in  2  engine result (00 tie, 01 P1, 10 P2, 11 invalid).
REQ-014 score_p1, score_p2  out  4 each  round wins in the current match.
REQ-015 round_cnt  out  5  rounds played in this match, ties and invalid rounds included.
REQ-016 busy  out  1  high in any state other than IDLE or DONE.
REQ-017 match_done  out  1  high in DONE.
REQ-018 match_winner  out  2  01 or 10 while in DONE, otherwise 00.
REQ-019 err  out  1  sticky flag, set by any invalid round in the current match.

Function
REQ-020 FSM states: IDLE, COLLECT, ISSUE, WAIT, SCORE, DONE.
REQ-021 IDLE/DONE + go -> COLLECT; scores, round_cnt and err clear on that same edge.
REQ-022 COLLECT latches each move on the first cycle its valid is high; later valids for a held move are ignored until SCORE.
REQ-023 When both moves are held (same-cycle arrival allowed) -> ISSUE next cycle.
REQ-024 ISSUE drives eng_start=1 for exactly one cycle; eng_p1/eng_p2 hold the latched moves from ISSUE through SCORE.
REQ-025 WAIT lasts RESULT_LAT cycles after ISSUE (counted by a 3-bit down-counter); eng_winner is sampled on its final cycle -> SCORE.
REQ-026 SCORE: 01 increments score_p1; 10 increments score_p2; 00 changes neither score; 11 sets err and changes neither score; round_cnt increments in every case (saturates at 31); move latches clear.
REQ-027 After SCORE: if either score == WIN_TARGET -> DONE, otherwise -> COLLECT.
REQ-028 Round latency: eng_start asserts 1 cycle after both moves are held; scores update RESULT_LAT+1 cycles after eng_start.
REQ-029 Scores never exceed WIN_TARGET; 4-bit unsigned arithmetic.
REQ-030 DONE holds all outputs stable until go or rst.
REQ-031 go while busy is ignored; it does not restart the match.

Reset
REQ-032 rst, asynchronous at any time including mid-round -> IDLE; all outputs 0, move latches and counters cleared.
REQ-033 eng_start is never asserted while rst is high or in the cycle after rst deasserts.

Configuration
REQ-034 With SPS_LFSR_OPP_EN defined, player 2 is internal: p2_move/p2_valid are ignored, and the P2 move is taken in COLLECT from an 8-bit LFSR (seed 8'hA5, reduced mod 3 so it is never 11) and counted as held immediately.
REQ-035 With SPS_LFSR_OPP_EN undefined, no LFSR exists and P2 comes only from p2_move/p2_valid.

Structure
REQ-036 Shared package sps_pkg holds the move and winner enums, the FSM state enum and the LFSR seed constant.
REQ-037 Sub-module sps_lfsr (8-bit Fibonacci, taps 8,6,5,4, advances every cycle) is instantiated only under SPS_LFSR_OPP_EN.

Verification
REQ-038 rst, go, moves 00/10, engine returns 01 -> eng_start 1 cycle after moves held; score_p1=1 at RESULT_LAT+1 after eng_start.
REQ-039 Three P1 wins with WIN_TARGET=3 -> match_done=1, match_winner=01, round_cnt=3, busy=0.
REQ-040 Tie (01/01, engine 00) then invalid (11/00, engine 11) -> scores 0/0, round_cnt=2, err=1.
REQ-041 p1_valid early with p2_valid 5 cycles later, plus p1_valid re-pulsed with a new move -> first P1 move used; single eng_start.
REQ-042 rst asserted in WAIT -> immediate IDLE, all outputs 0; new go starts clean with round_cnt=0.
REQ-043 SPS_LFSR_OPP_EN defined, p2_valid held 0 -> rounds proceed on p1_valid alone; eng_p2 is never 11.

Source files
------------

// File: rtl/sps_pkg.sv
// Shared types and constants for the stone/paper/scissors match controller.
package sps_pkg;

    typedef enum logic [1:0] {
        MV_STONE    = 2'b00,
        MV_PAPER    = 2'b01,
        MV_SCISSORS = 2'b10,
        MV_INVALID  = 2'b11
    } move_e;

    typedef enum logic [1:0] {
        WIN_TIE     = 2'b00,
        WIN_P1      = 2'b01,
        WIN_P2      = 2'b10,
        WIN_INVALID = 2'b11
    } winner_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_ISSUE   = 3'd2,
        ST_WAIT    = 3'd3,
        ST_SCORE   = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    localparam int unsigned LFSR_W    = 8;
    localparam logic [7:0]  LFSR_SEED = 8'hA5;

    // Fold an LFSR value onto the three legal moves (never MV_INVALID).
    function automatic logic [1:0] lfsr_mod3(input logic [7:0] v);
        return 2'(v % 8'd3);
    endfunction

endpackage

// File: rtl/sps_match_ctrl_if.sv
// Player, engine and status signals of the match controller.
interface sps_match_ctrl_if;
    logic       go;
    logic [1:0] p1_move;
    logic       p1_valid;
    logic [1:0] p2_move;
    logic       p2_valid;
    logic [1:0] eng_p1;
    logic [1:0] eng_p2;
    logic       eng_start;
    logic [1:0] eng_winner;
    logic [3:0] score_p1;
    logic [3:0] score_p2;
    logic [4:0] round_cnt;
    logic       busy;
    logic       match_done;
    logic [1:0] match_winner;
    logic       err;

    modport master (
        output go, p1_move, p1_valid, p2_move, p2_valid, eng_winner,
        input  eng_p1, eng_p2, eng_start, score_p1, score_p2, round_cnt,
               busy, match_done, match_winner, err
    );

    modport slave (
        input  go, p1_move, p1_valid, p2_move, p2_valid, eng_winner,
        output eng_p1, eng_p2, eng_start, score_p1, score_p2, round_cnt,
               busy, match_done, match_winner, err
    );
endinterface

// File: rtl/sps_lfsr.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) stepping every cycle; internal opponent source.
module sps_lfsr
    import sps_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    output logic [LFSR_W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= LFSR_SEED;
        else     q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    end

endmodule

// File: rtl/sps_match_ctrl.sv
// Stone/paper/scissors match controller: collects moves, drives the engine, keeps score.
// Optional SPS_LFSR_OPP_EN replaces player 2 with an internal LFSR opponent.
module sps_match_ctrl
    import sps_pkg::*;
#(
    parameter int unsigned WIN_TARGET = 3,
    parameter int unsigned RESULT_LAT = 2
) (
    input logic             clk,
    input logic             rst,
    sps_match_ctrl_if.slave bus
);

    localparam int unsigned SCORE_W = 4;
    localparam int unsigned RND_W   = 5;
    localparam int unsigned CNT_W   = 3;
    localparam logic [SCORE_W-1:0] WIN_T    = SCORE_W'(WIN_TARGET);
    localparam logic [CNT_W-1:0]   LAT_LOAD = CNT_W'(RESULT_LAT - 1);
    localparam logic [RND_W-1:0]   RND_MAX  = '1;

    state_e           state;
    logic [1:0]       p1_mv;
    logic [1:0]       p2_mv;
    logic             p1_held;
    logic             p2_held;
    logic [CNT_W-1:0] wait_cnt;

    logic       p2_src_valid_c;
    logic [1:0] p2_src_move_c;

`ifdef SPS_LFSR_OPP_EN
    logic [LFSR_W-1:0] lfsr_q;

    sps_lfsr u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_q)
    );

    // Internal opponent always has a move ready.
    assign p2_src_valid_c = 1'b1;
    assign p2_src_move_c  = lfsr_mod3(lfsr_q);
`else
    assign p2_src_valid_c = bus.p2_valid;
    assign p2_src_move_c  = bus.p2_move;
`endif

    // A move counts as available if already latched or arriving this cycle.
    logic       p1_have_c;
    logic       p2_have_c;
    logic [1:0] p1_now_c;
    logic [1:0] p2_now_c;

    assign p1_have_c = p1_held | bus.p1_valid;
    assign p2_have_c = p2_held | p2_src_valid_c;
    assign p1_now_c  = p1_held ? p1_mv : bus.p1_move;
    assign p2_now_c  = p2_held ? p2_mv : p2_src_move_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= ST_IDLE;
            p1_mv            <= '0;
            p2_mv            <= '0;
            p1_held          <= 1'b0;
            p2_held          <= 1'b0;
            wait_cnt         <= '0;
            bus.eng_p1       <= '0;
            bus.eng_p2       <= '0;
            bus.eng_start    <= 1'b0;
            bus.score_p1     <= '0;
            bus.score_p2     <= '0;
            bus.round_cnt    <= '0;
            bus.busy         <= 1'b0;
            bus.match_done   <= 1'b0;
            bus.match_winner <= '0;
            bus.err          <= 1'b0;
        end else begin
            bus.eng_start <= 1'b0;
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.go) begin
                        state            <= ST_COLLECT;
                        bus.score_p1     <= '0;
                        bus.score_p2     <= '0;
                        bus.round_cnt    <= '0;
                        bus.err          <= 1'b0;
                        bus.busy         <= 1'b1;
                        bus.match_done   <= 1'b0;
                        bus.match_winner <= '0;
                        p1_held          <= 1'b0;
                        p2_held          <= 1'b0;
                    end
                end
                ST_COLLECT: begin
                    if (bus.p1_valid && !p1_held) begin
                        p1_mv   <= bus.p1_move;
                        p1_held <= 1'b1;
                    end
                    if (p2_src_valid_c && !p2_held) begin
                        p2_mv   <= p2_src_move_c;
                        p2_held <= 1'b1;
                    end
                    if (p1_have_c && p2_have_c) begin
                        state         <= ST_ISSUE;
                        bus.eng_start <= 1'b1;
                        bus.eng_p1    <= p1_now_c;
                        bus.eng_p2    <= p2_now_c;
                    end
                end
                ST_ISSUE: begin
                    state    <= ST_WAIT;
                    wait_cnt <= LAT_LOAD;
                end
                ST_WAIT: begin
                    // Engine result is taken on the last WAIT cycle and is visible in SCORE.
                    if (wait_cnt == '0) begin
                        state <= ST_SCORE;
                        if (bus.round_cnt != RND_MAX) bus.round_cnt <= bus.round_cnt + RND_W'(1);
                        case (bus.eng_winner)
                            WIN_P1:      if (bus.score_p1 != WIN_T) bus.score_p1 <= bus.score_p1 + SCORE_W'(1);
                            WIN_P2:      if (bus.score_p2 != WIN_T) bus.score_p2 <= bus.score_p2 + SCORE_W'(1);
                            WIN_INVALID: bus.err <= 1'b1;
                            default:     ;
                        endcase
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                ST_SCORE: begin
                    p1_held <= 1'b0;
                    p2_held <= 1'b0;
                    if (bus.score_p1 == WIN_T || bus.score_p2 == WIN_T) begin
                        state            <= ST_DONE;
                        bus.busy         <= 1'b0;
                        bus.match_done   <= 1'b1;
                        bus.match_winner <= (bus.score_p1 == WIN_T) ? WIN_P1 : WIN_P2;
                    end else begin
                        state <= ST_COLLECT;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sps_match_ctrl.sv
// Self-checking bench for sps_match_ctrl: scripted match table, corner sequences, random matches.
module tb_sps_match_ctrl;

    localparam int unsigned WT = 3;
    localparam int unsigned RL = 2;

    logic clk;
    logic rst;

    sps_match_ctrl_if bus ();

    sps_match_ctrl #(.WIN_TARGET(WT), .RESULT_LAT(RL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Model of the scoreboard state seen after the previous round.
    logic [3:0] p_s1, p_s2;
    logic [4:0] p_rc;
    logic       p_err;

    typedef struct {
        bit         nm;
        logic [1:0] m1, m2, w;
        logic [3:0] s1, s2;
        logic [4:0] rc;
        logic       er, dn;
        logic [1:0] mw;
    } vec_t;

    vec_t tbl [9];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_zero(input string nm);
        chk(nm, 32'({bus.eng_p1, bus.eng_p2, bus.eng_start, bus.score_p1, bus.score_p2,
                     bus.round_cnt, bus.busy, bus.match_done, bus.match_winner, bus.err}), 32'd0);
    endtask

    task automatic do_go();
        bus.go = 1'b1;
        step();
        bus.go = 1'b0;
        chk("go_busy", 32'(bus.busy), 32'd1);
        chk("go_clear", 32'({bus.score_p1, bus.score_p2, bus.round_cnt, bus.err, bus.match_done}), 32'd0);
        p_s1 = '0; p_s2 = '0; p_rc = '0; p_err = 1'b0;
    endtask

    // One round: moves arrive after d1/d2 cycles, optional ignored re-pulses and a go while busy.
    task automatic play_round(input logic [1:0] m1, input logic [1:0] m2, input logic [1:0] w,
                              input int d1, input int d2, input bit noise, input bit go_mid,
                              input logic [3:0] e1, input logic [3:0] e2,
                              input logic [4:0] erc, input logic eerr);
        int last;
        bit early;
`ifdef SPS_LFSR_OPP_EN
        last = d1;
`else
        last = (d1 > d2) ? d1 : d2;
`endif
        early = 1'b0;
        for (int c = 0; c <= last; c++) begin
            bus.p1_valid = (c == d1) || (noise && c > d1);
            bus.p1_move  = (c == d1) ? m1 : 2'($urandom);
`ifdef SPS_LFSR_OPP_EN
            bus.p2_valid = 1'b0;
            bus.p2_move  = 2'b11;
`else
            bus.p2_valid = (c == d2) || (noise && c > d2);
            bus.p2_move  = (c == d2) ? m2 : 2'($urandom);
`endif
            bus.eng_winner = 2'($urandom);
            step();
            if (c < last && bus.eng_start) early = 1'b1;
        end
        bus.p1_valid = 1'b0;
        bus.p2_valid = 1'b0;
        chk("no_early_start", 32'(early), 32'd0);
        chk("start_latency", 32'(bus.eng_start), 32'd1);
        chk("eng_p1", 32'(bus.eng_p1), 32'(m1));
`ifdef SPS_LFSR_OPP_EN
        chk("eng_p2_legal", 32'(bus.eng_p2 == 2'b11), 32'd0);
`else
        chk("eng_p2", 32'(bus.eng_p2), 32'(m2));
`endif
        for (int k = 1; k <= int'(RL); k++) begin
            step();
            if (k == 1) chk("start_single", 32'(bus.eng_start), 32'd0);
            bus.go         = go_mid && (k == 1);
            bus.eng_winner = (k == int'(RL)) ? w : 2'($urandom);
        end
        bus.go = 1'b0;
        chk("score_hold", 32'({bus.score_p1, bus.score_p2, bus.round_cnt, bus.err}),
            32'({p_s1, p_s2, p_rc, p_err}));
        step();
        bus.eng_winner = 2'($urandom);
        chk("score_p1", 32'(bus.score_p1), 32'(e1));
        chk("score_p2", 32'(bus.score_p2), 32'(e2));
        chk("round_cnt", 32'(bus.round_cnt), 32'(erc));
        chk("err", 32'(bus.err), 32'(eerr));
        p_s1 = e1; p_s2 = e2; p_rc = erc; p_err = eerr;
        step();
    endtask

    initial begin
        logic [3:0] s1, s2;
        logic [4:0] rc;
        logic       er, dn;
        logic [1:0] w, m1, m2;

        // Two scripted matches: P1 sweep, then tie/invalid followed by a P2 win.
        tbl[0] = '{1'b1, 2'b00, 2'b10, 2'b01, 4'd1, 4'd0, 5'd1, 1'b0, 1'b0, 2'b00};
        tbl[1] = '{1'b0, 2'b01, 2'b00, 2'b01, 4'd2, 4'd0, 5'd2, 1'b0, 1'b0, 2'b00};
        tbl[2] = '{1'b0, 2'b10, 2'b01, 2'b01, 4'd3, 4'd0, 5'd3, 1'b0, 1'b1, 2'b01};
        tbl[3] = '{1'b1, 2'b01, 2'b01, 2'b00, 4'd0, 4'd0, 5'd1, 1'b0, 1'b0, 2'b00};
        tbl[4] = '{1'b0, 2'b11, 2'b00, 2'b11, 4'd0, 4'd0, 5'd2, 1'b1, 1'b0, 2'b00};
        tbl[5] = '{1'b0, 2'b00, 2'b01, 2'b10, 4'd0, 4'd1, 5'd3, 1'b1, 1'b0, 2'b00};
        tbl[6] = '{1'b0, 2'b00, 2'b01, 2'b10, 4'd0, 4'd2, 5'd4, 1'b1, 1'b0, 2'b00};
        tbl[7] = '{1'b0, 2'b10, 2'b01, 2'b01, 4'd1, 4'd2, 5'd5, 1'b1, 1'b0, 2'b00};
        tbl[8] = '{1'b0, 2'b00, 2'b01, 2'b10, 4'd1, 4'd3, 5'd6, 1'b1, 1'b1, 2'b10};

        rst = 1'b1;
        bus.go = 1'b0; bus.p1_move = '0; bus.p1_valid = 1'b0;
        bus.p2_move = '0; bus.p2_valid = 1'b0; bus.eng_winner = '0;
        p_s1 = '0; p_s2 = '0; p_rc = '0; p_err = 1'b0;
        step();
        chk_zero("reset_state");
        bus.go = 1'b1;
        step();
        chk_zero("go_in_reset");
        bus.go = 1'b0;
        rst = 1'b0;
        step();
        chk_zero("after_reset");

        for (int i = 0; i < 9; i++) begin
            if (tbl[i].nm) do_go();
            play_round(tbl[i].m1, tbl[i].m2, tbl[i].w, 0, i % 3, 1'b0, bit'(i % 2),
                       tbl[i].s1, tbl[i].s2, tbl[i].rc, tbl[i].er);
            chk("tbl_done", 32'(bus.match_done), 32'(tbl[i].dn));
            chk("tbl_busy", 32'(bus.busy), 32'(!tbl[i].dn));
            chk("tbl_winner", 32'(bus.match_winner), 32'(tbl[i].mw));
            if (tbl[i].dn) begin
                repeat (3) step();
                chk("done_hold", 32'({bus.match_done, bus.match_winner, bus.score_p1, bus.score_p2,
                                      bus.round_cnt, bus.busy, bus.eng_start}),
                    32'({1'b1, tbl[i].mw, tbl[i].s1, tbl[i].s2, tbl[i].rc, 1'b0, 1'b0}));
            end
        end

        // Early P1 with re-pulses, P2 five cycles later: first P1 move and one start only.
        do_go();
        play_round(2'b01, 2'b00, 2'b00, 0, 5, 1'b1, 1'b0, 4'd0, 4'd0, 5'd1, 1'b0);

        // Random matches against the score model.
        for (int m = 0; m < 6; m++) begin
            if (bus.busy) begin
                rst = 1'b1; step(); rst = 1'b0; step();
            end
            do_go();
            s1 = '0; s2 = '0; rc = '0; er = 1'b0;
            for (int r = 0; r < 40; r++) begin
                w  = 2'($urandom_range(0, 3));
                m1 = 2'($urandom);
                m2 = 2'($urandom);
                if (w == 2'b01) s1 = s1 + 4'd1;
                if (w == 2'b10) s2 = s2 + 4'd1;
                if (w == 2'b11) er = 1'b1;
                rc = (rc == 5'd31) ? rc : rc + 5'd1;
                play_round(m1, m2, w, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                           bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), s1, s2, rc, er);
                dn = (s1 == 4'(WT)) || (s2 == 4'(WT));
                chk("rnd_done", 32'(bus.match_done), 32'(dn));
                chk("rnd_busy", 32'(bus.busy), 32'(!dn));
                if (dn) begin
                    chk("rnd_winner", 32'(bus.match_winner), (s1 == 4'(WT)) ? 32'd1 : 32'd2);
                    break;
                end
            end
        end

        // Round counter saturation: 33 ties, then a P1 win with the counter pinned at 31.
        do_go();
        for (int r = 1; r <= 33; r++) begin
            play_round(2'b00, 2'b00, 2'b00, 0, 0, 1'b0, 1'b0, 4'd0, 4'd0,
                       (r > 31) ? 5'd31 : 5'(r), 1'b0);
        end
        play_round(2'b01, 2'b00, 2'b01, 0, 0, 1'b0, 1'b0, 4'd1, 4'd0, 5'd31, 1'b0);

        // Asynchronous reset while waiting on the engine.
        bus.p1_valid = 1'b1; bus.p1_move = 2'b10;
        bus.p2_valid = 1'b1; bus.p2_move = 2'b01;
        step();
        bus.p1_valid = 1'b0; bus.p2_valid = 1'b0;
        chk("rst_seq_start", 32'(bus.eng_start), 32'd1);
        step();
        #2 rst = 1'b1;
        #1 chk_zero("rst_async");
        step();
        chk_zero("rst_held");
        rst = 1'b0;
        step();
        chk_zero("rst_release");
        do_go();
        play_round(2'b00, 2'b10, 2'b01, 0, 0, 1'b0, 1'b0, 4'd1, 4'd0, 5'd1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
